// File: rtl/dual_delay_pkg.sv
// rtl/dual_delay_pkg.sv - shared types and helpers for the dual-rail delay comparator
package dual_delay_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        FAULT = 2'd2
    } ddc_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Tap 0 has no meaning (no stage to read), so it folds to the first stage.
    function automatic int tap_clamp(input int tap, input int ln);
        if (tap < 1) return 1;
        if (tap > ln) return ln;
        return tap;
    endfunction

endpackage

// File: rtl/delay_rail.sv
// rtl/delay_rail.sv - one NCH*DW shift rail, LN stages, with clear, enable and tap mux
module delay_rail
    import dual_delay_pkg::*;
#(
    parameter int DW  = 1,
    parameter int NCH = 1,
    parameter int LN  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clr,
    input  logic                   i_ce,
    input  logic [NCH*DW-1:0]      i_in,
    input  logic [clog2(LN)-1:0]   i_sel,
    output logic [NCH*DW-1:0]      o_tap
);

    localparam int W = NCH * DW;

    logic [W-1:0] stg [LN];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            for (int i = 0; i < LN; i++) stg[i] <= '0;
        end else if (i_ce) begin
            stg[0] <= i_in;
            for (int i = 1; i < LN; i++) stg[i] <= stg[i-1];
        end
    end

    assign o_tap = stg[i_sel];

endmodule

// File: rtl/dual_delay_cmp.sv
// rtl/dual_delay_cmp.sv - lockstep dual-rail delay line with tap comparator, fault FSM and error count
// Optional run-time tap selection: DDC_TAP_SEL_EN
module dual_delay_cmp
    import dual_delay_pkg::*;
#(
    parameter int DW  = 1,
    parameter int NCH = 1,
    parameter int LN  = 16,
    parameter int CW  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic [NCH*DW-1:0]      i_in,
    input  logic                   i_inject,
    input  logic                   i_clr,
    input  logic [clog2(LN+1)-1:0] i_tap,
    output logic [NCH*DW-1:0]      o_data,
    output logic                   o_valid,
    output logic                   o_mismatch,
    output logic                   o_fault,
    output logic [CW-1:0]          o_errcnt
);

    localparam int W  = NCH * DW;
    localparam int TW = clog2(LN + 1);
    localparam int SW = clog2(LN);

    ddc_state_t    state;
    logic [TW-1:0] fill;
    logic [TW-1:0] fill_nxt;
    logic [TW-1:0] depth;
    logic          depth_chg;
    logic          cmp_q;
    logic [W-1:0]  in_b;
    logic [W-1:0]  tap_a;
    logic [W-1:0]  tap_b;
    logic [SW-1:0] sel;
    logic          miss;

`ifdef DDC_TAP_SEL_EN
    logic [TW-1:0] depth_q;

    assign depth = TW'(tap_clamp(int'(i_tap), LN));

    always_ff @(posedge i_clk) depth_q <= depth;

    assign depth_chg = (depth != depth_q);
`else
    logic unused_tap;

    assign unused_tap = ^i_tap;
    assign depth      = TW'(LN);
    assign depth_chg  = 1'b0;
`endif

    assign sel = SW'(depth - TW'(1));

    always_comb begin
        in_b    = i_in;
        in_b[0] = i_in[0] ^ i_inject;
    end

    delay_rail #(.DW(DW), .NCH(NCH), .LN(LN)) u_rail_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_clr),
        .i_ce    (i_ce),
        .i_in    (i_in),
        .i_sel   (sel),
        .o_tap   (tap_a)
    );

    delay_rail #(.DW(DW), .NCH(NCH), .LN(LN)) u_rail_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_clr),
        .i_ce    (i_ce),
        .i_in    (in_b),
        .i_sel   (sel),
        .o_tap   (tap_b)
    );

    assign fill_nxt = (i_ce && fill < depth) ? fill + TW'(1) : fill;
    // Taps are only compared in the cycle after a shift, once the rails are known full.
    assign miss     = cmp_q && (state != FILL) && (tap_a != tap_b);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            state      <= FILL;
            fill       <= '0;
            cmp_q      <= 1'b0;
            o_mismatch <= 1'b0;
            o_errcnt   <= '0;
        end else begin
            cmp_q      <= i_ce;
            o_mismatch <= miss;
            if (miss && o_errcnt != {CW{1'b1}})
                o_errcnt <= o_errcnt + CW'(1);
            if (depth_chg) begin
                state <= FILL;
                fill  <= '0;
            end else begin
                fill <= fill_nxt;
                case (state)
                    FILL:    if (fill_nxt == depth) state <= ARMED;
                    ARMED:   if (miss) state <= FAULT;
                    FAULT:   state <= FAULT;
                    default: state <= FILL;
                endcase
            end
        end
    end

    assign o_data  = tap_a;
    assign o_valid = (state == ARMED) || (state == FAULT);
    assign o_fault = (state == FAULT);

endmodule

// File: tb/tb_dual_delay_cmp.sv
// tb/tb_dual_delay_cmp.sv - directed self-checking bench for dual_delay_cmp (LN=16, CW=8)
module tb_dual_delay_cmp;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [0:0] din;
    logic       inject;
    logic       clr;
    logic [4:0] tap;
    logic [0:0] data;
    logic       valid;
    logic       mismatch;
    logic       fault;
    logic [7:0] errcnt;

    int errors = 0;
    int checks = 0;

    dual_delay_cmp #(.DW(1), .NCH(1), .LN(16), .CW(8)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_ce       (ce),
        .i_in       (din),
        .i_inject   (inject),
        .i_clr      (clr),
        .i_tap      (tap),
        .o_data     (data),
        .o_valid    (valid),
        .o_mismatch (mismatch),
        .o_fault    (fault),
        .o_errcnt   (errcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; ce = 1'b1; din = 1'b1; inject = 1'b1; clr = 1'b0; tap = 5'd16;
        step; step;
        reset = 1'b0; ce = 1'b0; inject = 1'b0;
        checks++;
        if ({valid, mismatch, fault, errcnt, data} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b m=%0b f=%0b e=%0d d=%0b want all 0",
                     valid, mismatch, fault, errcnt, data);
        end
    endtask

    task automatic test_fill;
        ce = 1'b1; din = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step;
            if (k == 15) begin
                checks++;
                if (valid !== 1'b0 || data !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_15: got v=%0b d=%0b want v=0 d=0", valid, data);
                end
            end
        end
        checks++;
        if (valid !== 1'b1 || data !== 1'b1) begin
            errors++;
            $display("FAIL fill_16: got v=%0b d=%0b want v=1 d=1", valid, data);
        end
        checks++;
        if (mismatch !== 1'b0 || fault !== 1'b0 || errcnt !== 8'd0) begin
            errors++;
            $display("FAIL fill_clean: got m=%0b f=%0b e=%0d want 0 0 0", mismatch, fault, errcnt);
        end
    endtask

    task automatic test_inject;
        int first;
        int pulses;
        first = -1; pulses = 0;
        din = 1'b0; inject = 1'b1;
        step;
        inject = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step;
            if (mismatch) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (first !== 16 || pulses !== 1) begin
            errors++;
            $display("FAIL inject_pulse: got first=%0d pulses=%0d want first=16 pulses=1", first, pulses);
        end
        checks++;
        if (fault !== 1'b1 || errcnt !== 8'd1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL inject_fault: got f=%0b e=%0d v=%0b want f=1 e=1 v=1", fault, errcnt, valid);
        end
    endtask

    task automatic test_ce_gaps;
        int first;
        int pulses;
        int cnt;
        int exp_k;
        first = -1; pulses = 0; cnt = 0; exp_k = -1;
        ce = 1'b1; inject = 1'b1;
        step;
        inject = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            ce = (k % 4 == 0) || (k % 4 == 3);
            if (ce) begin
                cnt++;
                if (cnt == 15) exp_k = k + 1;
            end
            step;
            if (mismatch) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (first !== exp_k || pulses !== 1) begin
            errors++;
            $display("FAIL ce_gap_pulse: got first=%0d pulses=%0d want first=%0d pulses=1",
                     first, pulses, exp_k);
        end
        checks++;
        if (errcnt !== 8'd2 || fault !== 1'b1) begin
            errors++;
            $display("FAIL ce_gap_count: got e=%0d f=%0b want e=2 f=1", errcnt, fault);
        end
    endtask

    task automatic test_saturate;
        ce = 1'b1; inject = 1'b1;
        for (int k = 0; k < 300; k++) step;
        inject = 1'b0;
        for (int k = 0; k < 20; k++) step;
        checks++;
        if (errcnt !== 8'd255 || fault !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got e=%0d f=%0b want e=255 f=1", errcnt, fault);
        end
        clr = 1'b1;
        step;
        clr = 1'b0; ce = 1'b0;
        checks++;
        if ({valid, mismatch, fault, errcnt, data} !== 12'd0) begin
            errors++;
            $display("FAIL clr_outputs: got v=%0b m=%0b f=%0b e=%0d d=%0b want all 0",
                     valid, mismatch, fault, errcnt, data);
        end
    endtask

    task automatic test_clr_ce;
        ce = 1'b1; din = 1'b1;
        for (int k = 0; k < 5; k++) step;
        clr = 1'b1;
        step;
        clr = 1'b0; din = 1'b0;
        for (int k = 0; k < 15; k++) step;
        checks++;
        if (valid !== 1'b0 || data !== 1'b0) begin
            errors++;
            $display("FAIL clr_ce_drop: got v=%0b d=%0b want v=0 d=0", valid, data);
        end
        step;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL clr_ce_rearm: got v=%0b want 1", valid);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int k = 0; k < 15; k++) step;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midfill: got v=%0b want 0", valid);
        end
        step;
        checks++;
        if (valid !== 1'b1 || errcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_rearm: got v=%0b e=%0d want v=1 e=0", valid, errcnt);
        end
    endtask

`ifdef DDC_TAP_SEL_EN
    task automatic test_tap_sel;
        logic [7:0] e0;
        ce = 1'b1; inject = 1'b1;
        step;
        inject = 1'b0;
        for (int k = 0; k < 20; k++) step;
        e0 = errcnt;
        ce = 1'b0; tap = 5'd4;
        step;
        ce = 1'b1;
        for (int k = 0; k < 3; k++) step;
        checks++;
        if (valid !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL tap4_fill: got v=%0b f=%0b want 0 0", valid, fault);
        end
        step;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL tap4_arm: got v=%0b want 1", valid);
        end
        ce = 1'b0; tap = 5'd9;
        step;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL tap9_drop: got v=%0b want 0", valid);
        end
        ce = 1'b1;
        for (int k = 0; k < 8; k++) step;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL tap9_fill: got v=%0b want 0", valid);
        end
        step;
        checks++;
        if (valid !== 1'b1 || errcnt !== e0) begin
            errors++;
            $display("FAIL tap9_arm: got v=%0b e=%0d want v=1 e=%0d", valid, errcnt, e0);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_fill;
        test_inject;
        test_ce_gaps;
        test_saturate;
        test_clr_ce;
`ifdef DDC_TAP_SEL_EN
        test_tap_sel;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
